// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared defaults, widths and saturation helper for the LIF neuron array
package lif_pkg;
   localparam int DEF_N_NEURON   = 4;
   localparam int DEF_WIDTH      = 8;
   localparam int DEF_LEAK_SHIFT = 1;
   localparam int DEF_REFRAC     = 2;
   localparam int DEF_THRESH_RST = 200;
   localparam int CNT_W          = 16;
   localparam int REFR_W         = 4;

   function automatic int sat_max(input int w);
      return (1 << w) - 1;
   endfunction
endpackage

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - one leaky integrate-and-fire neuron with refractory counter and threshold register
module lif_neuron
   import lif_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
   parameter int REFRAC     = DEF_REFRAC,
   parameter int THRESH_RST = DEF_THRESH_RST
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] current,
   input  logic [WIDTH-1:0] weight,
   input  logic             thr_we,
   input  logic [WIDTH-1:0] thr_data,
   output logic             fire,
   output logic             spike,
   output logic [WIDTH-1:0] state
);
   localparam logic [WIDTH:0] SUM_MAX = (WIDTH+1)'(sat_max(WIDTH));

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   term;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   sum_sat;
   logic [WIDTH-1:0]   thresh;
   logic [REFR_W-1:0]  refr;

   // fire is the next value of spike; the array uses it to count on the same edge
   always_comb begin
      prod    = {{WIDTH{1'b0}}, current} * {{WIDTH{1'b0}}, weight};
      term    = prod[2*WIDTH-1:WIDTH];
      sum     = {1'b0, state} - {1'b0, (state >> LEAK_SHIFT)} + {1'b0, term};
      sum_sat = (sum > SUM_MAX) ? SUM_MAX[WIDTH-1:0] : sum[WIDTH-1:0];
      fire    = en && (refr == '0) && (sum_sat >= thresh);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= '0;
         refr   <= '0;
         spike  <= 1'b0;
         thresh <= WIDTH'(THRESH_RST);
      end else begin
         if (thr_we)
            thresh <= thr_data;
         spike <= fire;
         if (en) begin
            if (refr != '0) begin
               state <= '0;
               refr  <= refr - REFR_W'(1);
            end else if (fire) begin
               state <= '0;
               refr  <= REFR_W'(REFRAC);
            end else begin
               state <= sum_sat;
            end
         end
      end
   end
endmodule

// File: rtl/lif_array.sv
// rtl/lif_array.sv - chain of LIF neurons with per-neuron thresholds and a saturating spike counter
module lif_array
   import lif_pkg::*;
#(
   parameter int N_NEURON   = DEF_N_NEURON,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
   parameter int REFRAC     = DEF_REFRAC,
   parameter int THRESH_RST = DEF_THRESH_RST
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [WIDTH-1:0]    current_in,
   input  logic [WIDTH-1:0]    weight_in,
   input  logic                cfg_we,
   input  logic [((N_NEURON > 1) ? $clog2(N_NEURON) : 1)-1:0] cfg_addr,
   input  logic [WIDTH-1:0]    cfg_thresh,
   input  logic                cnt_clr,
   output logic [N_NEURON-1:0] spike_out,
   output logic [WIDTH-1:0]    state_last,
   output logic [CNT_W-1:0]    spike_cnt
);
   localparam int AW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
   localparam logic [WIDTH-1:0] W_FIX = WIDTH'(1) << (WIDTH-1);

   logic [WIDTH-1:0] cur [N_NEURON];
   logic [WIDTH-1:0] wt  [N_NEURON];
   logic [WIDTH-1:0] st  [N_NEURON];
   logic             fire [N_NEURON];
   logic [CNT_W-1:0] cnt_q;

   for (genvar i = 0; i < N_NEURON; i++) begin : g_neuron
      if (i == 0) begin : g_head
         assign cur[i] = current_in;
         assign wt[i]  = weight_in;
      end else begin : g_link
         // downstream neurons see the upstream spike as MSB over the halved state
         assign cur[i] = {spike_out[i-1], st[i-1][WIDTH-1:1]};
         assign wt[i]  = W_FIX;
      end

      lif_neuron #(
         .WIDTH      (WIDTH),
         .LEAK_SHIFT (LEAK_SHIFT),
         .REFRAC     (REFRAC),
         .THRESH_RST (THRESH_RST)
      ) u_neuron (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en),
         .current  (cur[i]),
         .weight   (wt[i]),
         .thr_we   (cfg_we && (cfg_addr == AW'(i))),
         .thr_data (cfg_thresh),
         .fire     (fire[i]),
         .spike    (spike_out[i]),
         .state    (st[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (cnt_clr)
         cnt_q <= '0;
      else if (fire[N_NEURON-1] && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign state_last = st[N_NEURON-1];
   assign spike_cnt  = cnt_q;
endmodule

// File: tb/tb_lif_array.sv
// tb/tb_lif_array.sv - randomized and directed self-checking bench for lif_array
module tb_lif_array;
   localparam int N  = 2;
   localparam int W  = 8;
   localparam int LS = 1;
   localparam int RF = 2;
   localparam int TR = 200;
   localparam int VMAX = (1 << W) - 1;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [W-1:0]  current_in;
   logic [W-1:0]  weight_in;
   logic          cfg_we;
   logic [0:0]    cfg_addr;
   logic [W-1:0]  cfg_thresh;
   logic          cnt_clr;
   logic [N-1:0]  spike_out;
   logic [W-1:0]  state_last;
   logic [15:0]   spike_cnt;

   int checks;
   int failures;

   int m_state [N];
   int m_refr  [N];
   int m_thr   [N];
   int m_spk   [N];
   int m_cnt;

   lif_array #(
      .N_NEURON   (N),
      .WIDTH      (W),
      .LEAK_SHIFT (LS),
      .REFRAC     (RF),
      .THRESH_RST (TR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .current_in (current_in),
      .weight_in  (weight_in),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_thresh (cfg_thresh),
      .cnt_clr    (cnt_clr),
      .spike_out  (spike_out),
      .state_last (state_last),
      .spike_cnt  (spike_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // reference behaviour: one enabled update per clock, computed from the neuron rules
   task automatic model_step();
      int ns [N];
      int nr [N];
      int nk [N];
      int c, wgt, term, sum;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_state[i] = 0; m_refr[i] = 0; m_spk[i] = 0; m_thr[i] = TR;
         end
         m_cnt = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            c    = (i == 0) ? int'(current_in) : (m_spk[i-1] * (1 << (W-1)) + m_state[i-1] / 2);
            wgt  = (i == 0) ? int'(weight_in) : (1 << (W-1));
            term = ((c * wgt) / (1 << W)) % (1 << W);
            if (!en) begin
               ns[i] = m_state[i]; nr[i] = m_refr[i]; nk[i] = 0;
            end else if (m_refr[i] > 0) begin
               ns[i] = 0; nr[i] = m_refr[i] - 1; nk[i] = 0;
            end else begin
               sum = m_state[i] - (m_state[i] >> LS) + term;
               if (sum > VMAX) sum = VMAX;
               if (sum >= m_thr[i]) begin
                  ns[i] = 0; nr[i] = RF; nk[i] = 1;
               end else begin
                  ns[i] = sum; nr[i] = 0; nk[i] = 0;
               end
            end
         end
         if (cnt_clr) m_cnt = 0;
         else if (nk[N-1] == 1 && m_cnt < 65535) m_cnt++;
         for (int i = 0; i < N; i++) begin
            m_state[i] = ns[i]; m_refr[i] = nr[i]; m_spk[i] = nk[i];
         end
         if (cfg_we && int'(cfg_addr) < N) m_thr[int'(cfg_addr)] = int'(cfg_thresh);
      end
   endtask

   task automatic compare_outputs();
      logic [N-1:0] e;
      for (int i = 0; i < N; i++) e[i] = (m_spk[i] != 0);
      check("spike_out", int'(spike_out), int'(e));
      check("state_last", int'(state_last), m_state[N-1]);
      check("spike_cnt", int'(spike_cnt), m_cnt);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      checks = 0; failures = 0;
      rst_n = 1'b0; en = 1'b0; current_in = '0; weight_in = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_thresh = '0; cnt_clr = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_state[i] = 0; m_refr[i] = 0; m_spk[i] = 0; m_thr[i] = TR;
      end
      m_cnt = 0;
      cycle();
      cycle();
      check("reset_spike", int'(spike_out), 0);
      check("reset_state", int'(state_last), 0);
      check("reset_cnt", int'(spike_cnt), 0);
      rst_n = 1'b1;

      // full-scale drive: spike, two refractory cycles, repeat
      en = 1'b1; current_in = 8'd255; weight_in = 8'd255;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         check("a_spike0", int'(spike_out[0]), (k % 3 == 1) ? 1 : 0);
         check("a_state0", int'(dut.st[0]), 0);
      end
      do_reset();
      check("a_rst_spike", int'(spike_out), 0);
      check("a_rst_cnt", int'(spike_cnt), 0);
      cycle();
      check("a_post_rst_spike0", int'(spike_out[0]), 1);

      // half-scale drive converges to 128 without spiking
      do_reset();
      current_in = 8'd128; weight_in = 8'd128;
      cycle(); check("b_st1", int'(dut.st[0]), 64);
      cycle(); check("b_st2", int'(dut.st[0]), 96);
      cycle(); check("b_st3", int'(dut.st[0]), 112);
      cycle(); check("b_st4", int'(dut.st[0]), 120);
      for (int k = 0; k < 16; k++) begin
         cycle();
         check("b_nospike", int'(spike_out[0]), 0);
      end
      check("b_conv", int'(dut.st[0]), 128);

      // threshold write coinciding with the first update
      do_reset();
      cfg_we = 1'b1; cfg_addr = 1'b0; cfg_thresh = 8'd100;
      cycle(); check("c_up1", int'(spike_out[0]), 0);
      cfg_we = 1'b0;
      cycle(); check("c_up2", int'(spike_out[0]), 0);
      cycle(); check("c_up3", int'(spike_out[0]), 1);

      // threshold 255 only reached through saturation
      do_reset();
      en = 1'b0; cfg_we = 1'b1; cfg_addr = 1'b0; cfg_thresh = 8'd255;
      cycle();
      cfg_we = 1'b0; en = 1'b1; current_in = 8'd255; weight_in = 8'd255;
      cycle(); check("d_st1", int'(dut.st[0]), 254); check("d_up1", int'(spike_out[0]), 0);
      cycle(); check("d_up2", int'(spike_out[0]), 1);

      // en low in the middle of a refractory period
      do_reset();
      cycle(); check("e_spike", int'(spike_out[0]), 1);
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle(); check("e_frozen", int'(spike_out[0]), 0);
      end
      en = 1'b1;
      cycle(); check("e_ref1", int'(spike_out[0]), 0);
      cycle(); check("e_ref2", int'(spike_out[0]), 0);
      cycle(); check("e_resume", int'(spike_out[0]), 1);

      // counter saturation and clear-wins
      do_reset();
      en = 1'b0; cfg_we = 1'b1; cfg_addr = 1'b1; cfg_thresh = 8'd0;
      cycle();
      cfg_we = 1'b0; en = 1'b1;
      for (int k = 0; k < 6; k++) cycle();
      check("f_cnt_pre", int'(spike_cnt), 2);
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      m_cnt = 65535;
      for (int k = 0; k < 9; k++) cycle();
      check("f_cnt_sat", int'(spike_cnt), 65535);
      found = 1'b0;
      for (int k = 0; k < 5 && !found; k++) begin
         if (m_refr[N-1] == 0) begin
            cnt_clr = 1'b1;
            cycle();
            cnt_clr = 1'b0;
            check("f_clr_spike", int'(spike_out[1]), 1);
            check("f_clr_cnt", int'(spike_cnt), 0);
            found = 1'b1;
         end else begin
            cycle();
         end
      end
      check("f_clr_found", int'(found), 1);

      // randomized run against the model
      for (int k = 0; k < 800; k++) begin
         rst_n      = ($urandom_range(0, 199) != 0);
         en         = ($urandom_range(0, 3) != 0);
         current_in = W'($urandom);
         weight_in  = ($urandom_range(0, 3) == 0) ? 8'd255 : W'($urandom);
         cfg_we     = ($urandom_range(0, 15) == 0);
         cfg_addr   = 1'($urandom_range(0, 1));
         cfg_thresh = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
         cnt_clr    = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lif_array.md
LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter N_NEURON, default 4: number of chained neurons, 1..16.
REQ-002 Parameter WIDTH, default 8: membrane state, current, weight and threshold width, 4..16.
REQ-003 Parameter LEAK_SHIFT, default 1: leak is state >> LEAK_SHIFT per update, 1..WIDTH-1.
REQ-004 Parameter REFRAC, default 2: refractory cycles after a spike, 0..15.
REQ-005 Parameter THRESH_RST, default 200: per-neuron threshold value after reset.
REQ-006 clk  in  1  sole clock; all logic rising-edge.
REQ-007 rst_n  in  1  reset; one clock, synchronous, active-low.
REQ-008 en  in  1  update enable; 0 = freeze membrane and refractory state.
REQ-009 current_in  in  WIDTH  input current to neuron 0.
REQ-010 weight_in  in  WIDTH  input weight to neuron 0.
REQ-011 cfg_we  in  1  threshold write strobe.
REQ-012 cfg_addr  in  clog2(N_NEURON), minimum 1 bit  neuron index for the threshold write.
REQ-013 cfg_thresh  in  WIDTH  threshold write data.
REQ-014 cnt_clr  in  1  clears the spike counter.
REQ-015 spike_out  out  N_NEURON  registered spike flag per neuron.
REQ-016 state_last  out  WIDTH  membrane state of neuron N_NEURON-1.
REQ-017 spike_cnt  out  16  saturating spike count of neuron N_NEURON-1.

Function
REQ-018 Neuron 0 SHALL take current_in and weight_in; neuron i>0 SHALL take current {spike[i-1], state[i-1][WIDTH-1:1]} and fixed weight 2^(WIDTH-1).
REQ-019 Input term SHALL be (current*weight) >> WIDTH, unsigned, truncated to WIDTH bits.
REQ-020 With en=1, a non-refractory neuron SHALL compute sum = state - (state>>LEAK_SHIFT) + term in WIDTH+1 bits and saturate it to 2^WIDTH-1.
REQ-021 If sum >= thresh[i], the neuron SHALL register spike=1, state=0 and refractory count=REFRAC; otherwise it SHALL register spike=0 and state=sum.
REQ-022 While refractory count > 0 with en=1, the neuron SHALL register spike=0 and state=0, decrement the count, and ignore its input.
REQ-023 With en=0, state and refractory counts SHALL hold, and spike_out SHALL register 0.
REQ-024 Latency: a spike SHALL appear on spike_out one cycle after the sampled inputs, with one additional cycle per chain stage.
REQ-025 A threshold write SHALL take effect on the cycle after cfg_we; an update in the same cycle SHALL use the old threshold; a cfg_addr >= N_NEURON SHALL be ignored.
REQ-026 Threshold 0 SHALL make the neuron spike on every non-refractory enabled cycle.
REQ-027 spike_cnt SHALL increment when spike_out[N_NEURON-1] registers 1 and SHALL saturate at 65535.
REQ-028 cnt_clr SHALL set spike_cnt to 0 and SHALL win over a simultaneous increment.

Reset
REQ-029 On rst_n=0 at a clock edge, the block SHALL set all states, refractory counts, spike_out, state_last and spike_cnt to 0, and all thresholds to THRESH_RST.
REQ-030 Reset SHALL override en, cfg_we and cnt_clr, and SHALL abort a refractory period mid-count.

Structure
REQ-031 Package lif_pkg SHALL hold the parameter defaults, the saturation-maximum helper and the counter width constant (16).
REQ-032 One sub-module, lif_neuron (state, refractory counter, threshold register, spike register), SHALL be instantiated N_NEURON times by a generate loop.

Verification (N_NEURON=2, WIDTH=8, LEAK_SHIFT=1, REFRAC=2, THRESH_RST=200)
REQ-033 current=255, weight=255, en=1 -> term 254; spike_out[0]=1 on the 1st update, then every 3rd cycle; state 0 during the 2 refractory cycles.
REQ-034 current=128, weight=128 -> state0 sequence 64, 96, 112, 120, ..., converging to 128; spike_out[0] never set.
REQ-035 Same stimulus as REQ-034, after writing cfg_addr=0, cfg_thresh=100 -> spike_out[0]=1 on the 3rd update (sum 112); an update coinciding with the write uses 200.
REQ-036 thresh[0]=255, term 254 -> sums 254, then 381 saturated to 255; spike on the 2nd update.
REQ-037 en deasserted mid-refractory holds the count and forces spike_out=0; rst_n=0 mid-run gives all outputs 0 and thresholds 200 on the next cycle.
REQ-038 Force spike_cnt to 65535 -> further spikes hold it at 65535; cnt_clr coinciding with a spike -> spike_cnt=0.
